// File: rtl/bcd_updown_counter_mux_if.sv
// Button / display bundle of the multi-digit BCD up/down counter.
// master: button/strap side (drives ena, buttons, mode_sat); slave: the counter.
interface bcd_cnt_if #(
    parameter int DIGITS = 4
);
    logic                  ena;
    logic                  inc_n;
    logic                  dec_n;
    logic                  clr_n;
    logic                  mode_sat;
    logic [4*DIGITS-1:0]   count_o;
    logic                  wrap_o;
    logic [7:0]            seg_o;
    logic [DIGITS-1:0]     dig_sel_o;

    modport master (
        output ena, inc_n, dec_n, clr_n, mode_sat,
        input  count_o, wrap_o, seg_o, dig_sel_o
    );

    modport slave (
        input  ena, inc_n, dec_n, clr_n, mode_sat,
        output count_o, wrap_o, seg_o, dig_sel_o
    );
endinterface

// File: rtl/bcd_updown_counter_mux.sv
// Multi-digit BCD up/down event counter with scanned 7-segment drive.
// Buttons are synchronised (2 FF), edge-detected on the falling edge and applied
// to a DIGITS-decade BCD count with wrap or saturate at the limits.
// Optional macro DEBOUNCE_EN inserts a DEB_CYCLES stable-sample filter per button.
module bcd_updown_counter_mux #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CYCLES = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    bcd_cnt_if.slave bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW = $clog2(SCAN_DIV);
`ifdef DEBOUNCE_EN
    // Edge detection arms once the filter output reflects the real pin level.
    localparam int ARM_CYC = 2 + DEB_CYCLES;
`else
    // Filter depth is irrelevant without the filter; arming only covers the synchroniser.
    localparam int ARM_CYC = 2 + 0 * DEB_CYCLES;
`endif
    localparam int AW = $clog2(ARM_CYC + 1);

    // Button vectors are {clr, dec, inc}.
    logic [2:0]             btn_s1, btn_s2, btn_lvl, btn_d, ev_q;
    logic [AW-1:0]          arm_cnt;
    logic                   armed;
    logic [DIGITS-1:0][3:0] count_q, count_nxt;
    logic                   wrap_q, wrap_nxt;
    logic [DW-1:0]          div_q;
    logic [IW-1:0]          idx_q;
    logic [7:0]             seg_q;
    logic [DIGITS-1:0]      dig_sel_q;

    // One BCD step up or down with decade carry/borrow; wraps silently at the ends.
    function automatic logic [DIGITS-1:0][3:0] bcd_step(input logic [DIGITS-1:0][3:0] v,
                                                        input logic up);
        logic [DIGITS-1:0][3:0] r;
        logic                   c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (up) begin
                    if (v[i] == 4'd9) r[i] = 4'd0;
                    else begin r[i] = v[i] + 4'd1; c = 1'b0; end
                end else begin
                    if (v[i] == 4'd0) r[i] = 4'd9;
                    else begin r[i] = v[i] - 4'd1; c = 1'b0; end
                end
            end
        end
        return r;
    endfunction

    // gfedcba pattern for one BCD digit; non-decimal codes are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Two-flop synchroniser, idle (released) level after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= '1;
            btn_s2 <= '1;
        end else begin
            btn_s1 <= {bus.clr_n, bus.dec_n, bus.inc_n};
            btn_s2 <= btn_s1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [2:0][CW-1:0] deb_cnt;

    // Filtered level follows the synchronised level after DEB_CYCLES equal samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            btn_lvl <= '1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (btn_s2[i] == btn_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    btn_lvl[i] <= btn_s2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end
`else
    assign btn_lvl = btn_s2;
`endif

    assign armed = (arm_cnt == AW'(ARM_CYC));

    // Falling-edge detect. The previous-level flop only loads real pin data once
    // the reset values have flushed out, so a button held through reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt <= '0;
            btn_d   <= '0;
            ev_q    <= '0;
        end else begin
            if (!armed) arm_cnt <= arm_cnt + AW'(1);
            btn_d <= armed ? btn_lvl : 3'b000;
            ev_q  <= btn_d & ~btn_lvl;
        end
    end

    // Next count: clr > (inc & dec cancel) > inc > dec; limits wrap or saturate.
    always_comb begin
        count_nxt = count_q;
        wrap_nxt  = 1'b0;
        if (bus.ena) begin
            if (ev_q[2]) begin
                count_nxt = '0;
            end else if (ev_q[0] && ev_q[1]) begin
                count_nxt = count_q;
            end else if (ev_q[0]) begin
                if (count_q == {DIGITS{4'h9}}) begin
                    if (!bus.mode_sat) begin
                        count_nxt = '0;
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = bcd_step(count_q, 1'b1);
                end
            end else if (ev_q[1]) begin
                if (count_q == '0) begin
                    if (!bus.mode_sat) begin
                        count_nxt = {DIGITS{4'h9}};
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = bcd_step(count_q, 1'b0);
                end
            end
        end
    end

    // Count and wrap pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_nxt;
            wrap_q  <= wrap_nxt;
        end
    end

    // Scan divider and digit index; parked at 0 while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (!bus.ena) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DW'(SCAN_DIV - 1)) begin
            div_q <= '0;
            idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    // Registered display drive; dp on digit 0 shows saturate mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q     <= '0;
            dig_sel_q <= '0;
        end else if (!bus.ena) begin
            seg_q     <= '0;
            dig_sel_q <= '0;
        end else begin
            seg_q     <= {(idx_q == '0) & bus.mode_sat, seg_decode(count_q[idx_q])};
            dig_sel_q <= DIGITS'(1) << idx_q;
        end
    end

    assign bus.count_o   = count_q;
    assign bus.wrap_o    = wrap_q;
    assign bus.seg_o     = seg_q;
    assign bus.dig_sel_o = dig_sel_q;
endmodule

// File: tb/tb_bcd_updown_counter_mux.sv
// Bench for bcd_updown_counter_mux: directed limit/carry/scan steps plus random
// button operations checked against an integer-valued reference model.
module tb_bcd_updown_counter_mux;
    localparam int DIGITS = 4;
    localparam int SD     = 4;
    localparam int DEB    = 16;
    localparam int LIM    = 10**DIGITS - 1;
`ifdef DEBOUNCE_EN
    localparam int LAT = 3 + DEB, HOLD = DEB + 4, SETTLE = DEB + 8, WP = DEB + 1;
`else
    localparam int LAT = 3, HOLD = 1, SETTLE = 2, WP = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mval = 0;
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    bcd_cnt_if #(.DIGITS(DIGITS)) bus ();

    bcd_updown_counter_mux #(.DIGITS(DIGITS), .SCAN_DIV(SD), .DEB_CYCLES(DEB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int t;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Press the chosen buttons together; model the result and check before/at/after the update edge.
    task automatic apply(input bit pi, input bit pd, input bit pc, input string tag);
        int ev;
        bit ew;
        ev = mval;
        ew = 1'b0;
        if (bus.ena) begin
            if (pc) ev = 0;
            else if (pi && pd) ev = mval;
            else if (pi) begin
                if (mval == LIM) begin if (!bus.mode_sat) begin ev = 0; ew = 1'b1; end end
                else ev = mval + 1;
            end else if (pd) begin
                if (mval == 0) begin if (!bus.mode_sat) begin ev = LIM; ew = 1'b1; end end
                else ev = mval - 1;
            end
        end
        bus.inc_n = ~pi;
        bus.dec_n = ~pd;
        bus.clr_n = ~pc;
        for (int e = 0; e <= LAT + 1; e++) begin
            @(posedge clk); #1;
            if (e == HOLD - 1) begin bus.inc_n = 1'b1; bus.dec_n = 1'b1; bus.clr_n = 1'b1; end
            if (e == LAT - 1) chk({tag, "_pre"}, 32'(bus.count_o), 32'(to_bcd(mval)));
            if (e == LAT) begin
                chk({tag, "_cnt"}, 32'(bus.count_o), 32'(to_bcd(ev)));
                chk({tag, "_wrap"}, 32'(bus.wrap_o), 32'(ew));
            end
            if (e == LAT + 1) chk({tag, "_wrap_end"}, 32'(bus.wrap_o), 32'd0);
        end
        mval = ev;
        repeat (SETTLE) @(posedge clk);
        #1;
    endtask

    // n quick increments, no limit crossing.
    task automatic walk(input int n);
        repeat (n) begin
            bus.inc_n = 1'b0;
            repeat (WP) @(posedge clk);
            #1 bus.inc_n = 1'b1;
            repeat (WP) @(posedge clk);
            #1;
        end
        mval = mval + n;
        repeat (LAT + SETTLE) @(posedge clk);
        #1;
    endtask

    // Restart the scan through ena and follow n cycles of digit selection.
    task automatic scan_chk(input int n);
        int k, p;
        logic [7:0] es;
        @(posedge clk); #1 bus.ena = 1'b0;
        @(posedge clk); #1;
        chk("scan_off_seg", 32'(bus.seg_o), 32'd0);
        chk("scan_off_sel", 32'(bus.dig_sel_o), 32'd0);
        bus.ena = 1'b1;
        for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
            k = (j / SD) % DIGITS;
            p = 1;
            repeat (k) p = p * 10;
            es = {(k == 0) && bus.mode_sat, seg_tab[(mval / p) % 10]};
            chk("scan_sel", 32'(bus.dig_sel_o), 32'(1 << k));
            chk("scan_seg", 32'(bus.seg_o), 32'(es));
        end
    endtask

    initial begin
        bus.ena      = 1'b1;
        bus.inc_n    = 1'b0;
        bus.dec_n    = 1'b1;
        bus.clr_n    = 1'b1;
        bus.mode_sat = 1'b0;

        // Reset with inc held across release.
        repeat (5) @(posedge clk);
        #1;
        chk("rst_cnt", 32'(bus.count_o), 32'd0);
        chk("rst_wrap", 32'(bus.wrap_o), 32'd0);
        chk("rst_seg", 32'(bus.seg_o), 32'd0);
        chk("rst_sel", 32'(bus.dig_sel_o), 32'd0);
        rst_n = 1'b1;
        repeat (DEB + 10) @(posedge clk);
        #1 bus.inc_n = 1'b1;
        repeat (LAT + SETTLE + 4) @(posedge clk);
        #1;
        chk("rst_held_inc", 32'(bus.count_o), 32'd0);

        // Single press latency, then a long hold counts once.
        apply(1, 0, 0, "inc1");
        bus.inc_n = 1'b0;
        repeat (100) @(posedge clk);
        #1 bus.inc_n = 1'b1;
        repeat (LAT + SETTLE + 4) @(posedge clk);
        #1;
        mval = mval + 1;
        chk("long_hold", 32'(bus.count_o), 32'(to_bcd(mval)));

        // Carry and borrow across decades.
        apply(0, 0, 1, "clr");
        walk(9);
        chk("walk9", 32'(bus.count_o), 32'h0009);
        apply(1, 0, 0, "carry10");
        walk(989);
        chk("walk999", 32'(bus.count_o), 32'h0999);
        apply(1, 0, 0, "carry1000");
        apply(0, 1, 0, "borrow999");
        walk(235);
        chk("walk1234", 32'(bus.count_o), 32'h1234);

        // Scan at 0x1234, then dp on digit 0 in saturate mode.
        scan_chk(20);
        bus.mode_sat = 1'b1;
        scan_chk(6);
        bus.mode_sat = 1'b0;

        apply(1, 1, 0, "inc_dec");
        apply(1, 0, 1, "clr_inc");

        // Limits.
        apply(0, 1, 0, "wrap_lo");
        bus.mode_sat = 1'b1;
        apply(1, 0, 0, "sat_hi");
        bus.mode_sat = 1'b0;
        apply(1, 0, 0, "wrap_hi");
        bus.mode_sat = 1'b1;
        apply(0, 1, 0, "sat_lo");
        bus.mode_sat = 1'b0;

        // Disabled: events dropped, display dark.
        bus.ena = 1'b0;
        apply(1, 0, 0, "ena_off");
        chk("ena_off_seg", 32'(bus.seg_o), 32'd0);
        chk("ena_off_sel", 32'(bus.dig_sel_o), 32'd0);
        bus.ena = 1'b1;

`ifdef DEBOUNCE_EN
        // A glitch shorter than the filter depth is ignored.
        bus.inc_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.inc_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("deb_glitch", 32'(bus.count_o), 32'(to_bcd(mval)));
`endif

        // Random operations against the model.
        for (int n = 0; n < 30; n++) begin
            int r;
            r = $urandom_range(0, 9);
            bus.mode_sat = 1'($urandom_range(0, 1));
            if (r == 0)      apply(0, 0, 1, "rnd_clr");
            else if (r == 1) apply(1, 1, 0, "rnd_both");
            else if (r < 6)  apply(1, 0, 0, "rnd_inc");
            else             apply(0, 1, 0, "rnd_dec");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
